// File: rtl/uart_rx_baud_ctrl.sv
// Baud-rate timing sequencer for the UART receiver: start-bit centring and per-bit sample
// strobes, a runtime-loadable divisor deferred to idle, and a per-frame tick watchdog.
module uart_rx_baud_ctrl #(
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter int unsigned DEFAULT_BAUD = 115200,
  parameter int unsigned DIV_W        = 16,
  parameter int unsigned MAX_TICKS    = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] baud_div_i,
  input  logic             baud_div_load,
  input  logic             rx_en,
  input  logic             rx_start_align,
  output logic             rx_half_baud_tick,
  output logic             rx_baud_tick,
  output logic [DIV_W-1:0] baud_div_o,
  output logic             cfg_pending,
  output logic             cfg_err,
  output logic             frame_timeout
);

  localparam int unsigned      TcW    = $clog2(MAX_TICKS + 1);
  localparam logic [DIV_W-1:0] DefDiv = DIV_W'(CLK_FREQ / DEFAULT_BAUD);
  localparam logic [DIV_W-1:0] MinDiv = DIV_W'(4);
  localparam logic [TcW-1:0]   MaxTc  = TcW'(MAX_TICKS);

  typedef enum logic [1:0] {StIdle, StHalf, StFull, StHold} state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [TcW-1:0]   tc_q, tc_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pval_q, pval_d;
  logic             pend_q, pend_d;
  logic             half_q, half_d;
  logic             baud_q, baud_d;
  logic             to_q, to_d;
  logic             err_q, err_d;

  logic [DIV_W-1:0] load_val;
  logic [DIV_W-1:0] half_last;
  logic [DIV_W-1:0] full_last;
  logic             resync;

  assign load_val  = (baud_div_i < MinDiv) ? MinDiv : baud_div_i;
  // Counters start at 0 the edge after the reference, so the strobe fires on count N-1.
  assign half_last = (div_q >> 1) - DIV_W'(1);
  assign full_last = div_q - DIV_W'(1);
  assign resync    = rx_start_align && rx_en;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tc_d    = tc_q;
    half_d  = 1'b0;
    baud_d  = 1'b0;
    to_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        tc_d  = '0;
        if (resync) state_d = StHalf;
      end
      StHalf: begin
        if (!rx_en) begin
          state_d = StIdle;
          cnt_d   = '0;
          tc_d    = '0;
        end else if (rx_start_align) begin
          cnt_d = '0;
          tc_d  = '0;
        end else if (cnt_q == half_last) begin
          half_d  = 1'b1;
          state_d = StFull;
          cnt_d   = '0;
          tc_d    = '0;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      StFull: begin
        if (!rx_en) begin
          state_d = StIdle;
          cnt_d   = '0;
          tc_d    = '0;
        end else if (rx_start_align) begin
          state_d = StHalf;
          cnt_d   = '0;
          tc_d    = '0;
        end else if (cnt_q == full_last) begin
          cnt_d = '0;
          if (tc_q == MaxTc) begin
            to_d    = 1'b1;
            state_d = StHold;
          end else begin
            baud_d = 1'b1;
            tc_d   = tc_q + TcW'(1);
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      StHold: begin
        cnt_d = '0;
        if (!rx_en) begin
          state_d = StIdle;
          tc_d    = '0;
        end else if (rx_start_align) begin
          state_d = StHalf;
          tc_d    = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        tc_d    = '0;
      end
    endcase
  end

  // A divisor change never lands mid-frame; it waits in pval_q until the sequencer is idle.
  always_comb begin
    div_d  = div_q;
    pend_d = pend_q;
    pval_d = pval_q;
    err_d  = 1'b0;
    if (state_q == StIdle && pend_q) begin
      div_d  = pval_q;
      pend_d = 1'b0;
    end
    if (baud_div_load) begin
      err_d = (baud_div_i < MinDiv);
      if (state_q == StIdle) begin
        div_d  = load_val;
        pend_d = 1'b0;
      end else begin
        pval_d = load_val;
        pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      tc_q    <= '0;
      div_q   <= DefDiv;
      pval_q  <= '0;
      pend_q  <= 1'b0;
      half_q  <= 1'b0;
      baud_q  <= 1'b0;
      to_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tc_q    <= tc_d;
      div_q   <= div_d;
      pval_q  <= pval_d;
      pend_q  <= pend_d;
      half_q  <= half_d;
      baud_q  <= baud_d;
      to_q    <= to_d;
      err_q   <= err_d;
    end
  end

  assign rx_half_baud_tick = half_q;
  assign rx_baud_tick      = baud_q;
  assign baud_div_o        = div_q;
  assign cfg_pending       = pend_q;
  assign cfg_err           = err_q;
  assign frame_timeout     = to_q;

endmodule

// File: tb/tb_uart_rx_baud_ctrl.sv
// Bench for uart_rx_baud_ctrl: scoreboard of expected strobe cycles plus a divisor-load table.
module tb_uart_rx_baud_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] baud_div_i;
  logic        baud_div_load;
  logic        rx_en;
  logic        rx_start_align;
  logic        rx_half_baud_tick;
  logic        rx_baud_tick;
  logic [15:0] baud_div_o;
  logic        cfg_pending;
  logic        cfg_err;
  logic        frame_timeout;

  uart_rx_baud_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .baud_div_i       (baud_div_i),
    .baud_div_load    (baud_div_load),
    .rx_en            (rx_en),
    .rx_start_align   (rx_start_align),
    .rx_half_baud_tick(rx_half_baud_tick),
    .rx_baud_tick     (rx_baud_tick),
    .baud_div_o       (baud_div_o),
    .cfg_pending      (cfg_pending),
    .cfg_err          (cfg_err),
    .frame_timeout    (frame_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int kind;  // 0 half tick, 1 baud tick, 2 frame timeout
  } ev_t;
  ev_t exp_q[$];

  typedef struct {
    logic [15:0] din;
    logic [15:0] dout;
    logic        err;
  } vec_t;
  vec_t vecs[7];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d (cyc %0d)", name, got, want, cyc);
    end
  endtask

  task automatic sb_pop(input int kind);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_pulse kind=%0d at cyc=%0d want none", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc) begin
        failures++;
        $display("FAIL pulse got kind=%0d cyc=%0d want kind=%0d cyc=%0d", kind, cyc, e.kind,
                 e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_half_baud_tick) sb_pop(0);
      if (rx_baud_tick) sb_pop(1);
      if (frame_timeout) sb_pop(2);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push(input int c, input int kind);
    ev_t e;
    e.cyc  = c;
    e.kind = kind;
    exp_q.push_back(e);
  endtask

  task automatic load(input logic [15:0] v);
    baud_div_i    = v;
    baud_div_load = 1'b1;
    tick();
    baud_div_load = 1'b0;
  endtask

  // Start a frame; align is sampled at edge k. Returns the cycle of the last expected pulse.
  task automatic frame_begin(input int div, input int n, input bit to, output int last);
    int h;
    int k;
    h = div / 2;
    rx_en          = 1'b1;
    rx_start_align = 1'b1;
    tick();
    k              = cyc;
    rx_start_align = 1'b0;
    push(k + h, 0);
    last = k + h;
    for (int i = 1; i <= n; i++) begin
      push(k + h + i * div, 1);
      last = k + h + i * div;
    end
    if (to) begin
      push(k + h + (n + 1) * div, 2);
      last = k + h + (n + 1) * div;
    end
  endtask

  task automatic frame_end(input string name);
    rx_en = 1'b0;
    repeat (3) tick();
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #900_000;
    $display("FAIL global_time_limit cyc=%0d", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    int last;
    vecs[0] = '{din: 16'd100, dout: 16'd100, err: 1'b0};
    vecs[1] = '{din: 16'd2,   dout: 16'd4,   err: 1'b1};
    vecs[2] = '{din: 16'd0,   dout: 16'd4,   err: 1'b1};
    vecs[3] = '{din: 16'd3,   dout: 16'd4,   err: 1'b1};
    vecs[4] = '{din: 16'd4,   dout: 16'd4,   err: 1'b0};
    vecs[5] = '{din: 16'd434, dout: 16'd434, err: 1'b0};
    vecs[6] = '{din: 16'd5,   dout: 16'd5,   err: 1'b0};

    rst_n          = 1'b0;
    baud_div_i     = '0;
    baud_div_load  = 1'b0;
    rx_en          = 1'b0;
    rx_start_align = 1'b0;
    repeat (3) tick();
    check("rst_div", baud_div_o, 434);
    check("rst_pending", cfg_pending, 0);
    check("rst_ticks", {rx_half_baud_tick, rx_baud_tick, frame_timeout, cfg_err}, 0);
    rst_n = 1'b1;
    repeat (2) tick();
    check("post_rst_div", baud_div_o, 434);

    // Default divisor frame: half at k+217, ticks every 434.
    frame_begin(434, 9, 1'b0, last);
    wait_until(last + 2);
    frame_end("f434_drained");

    // Mid-frame load is deferred; frame keeps 434.
    frame_begin(434, 3, 1'b0, last);
    wait_until(last - 300);
    load(16'd200);
    check("defer_pending", cfg_pending, 1);
    check("defer_div", baud_div_o, 434);
    wait_until(last + 2);
    check("defer_div_frame_end", baud_div_o, 434);
    frame_end("defer_drained");
    check("defer_applied_div", baud_div_o, 200);
    check("defer_applied_pending", cfg_pending, 0);

    // Loads in idle, including clamping.
    for (int i = 0; i < 7; i++) begin
      load(vecs[i].din);
      check($sformatf("tbl%0d_div", i), baud_div_o, vecs[i].dout);
      check($sformatf("tbl%0d_err", i), cfg_err, vecs[i].err);
      check($sformatf("tbl%0d_pending", i), cfg_pending, 0);
      tick();
      check($sformatf("tbl%0d_err_clr", i), cfg_err, 0);
    end

    load(16'd100);
    frame_begin(100, 3, 1'b0, last);
    wait_until(last + 2);
    frame_end("f100_drained");

    load(16'd5);
    frame_begin(5, 4, 1'b0, last);
    wait_until(last + 2);
    frame_end("f5_drained");

    // Watchdog: 12 ticks, 13th replaced by frame_timeout, silence while rx_en stays high.
    frame_begin(5, 12, 1'b1, last);
    wait_until(last + 30);
    check("wd_drained_hold", exp_q.size(), 0);
    frame_end("wd_drained");

    // rx_en drops on the edge a tick is due.
    frame_begin(5, 0, 1'b0, last);
    wait_until(last + 4);
    rx_en = 1'b0;
    repeat (15) tick();
    check("drop_before_tick", exp_q.size(), 0);

    // rx_en low together with align mid-frame: no resync.
    frame_begin(5, 1, 1'b0, last);
    wait_until(last + 2);
    rx_en          = 1'b0;
    rx_start_align = 1'b1;
    tick();
    rx_start_align = 1'b0;
    repeat (20) tick();
    check("drop_with_align", exp_q.size(), 0);

    // Align while rx_en low in idle is ignored.
    rx_start_align = 1'b1;
    tick();
    rx_start_align = 1'b0;
    repeat (10) tick();
    check("idle_align_ignored", exp_q.size(), 0);

    // Asynchronous reset mid-FULL with a pending load.
    frame_begin(5, 3, 1'b0, last);
    wait_until(last - 13);
    load(16'd50);
    check("rst_mid_pending", cfg_pending, 1);
    wait_until(last - 6);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("rst_mid_div", baud_div_o, 434);
    check("rst_mid_pending_clr", cfg_pending, 0);
    check("rst_mid_outs", {rx_half_baud_tick, rx_baud_tick, frame_timeout, cfg_err}, 0);
    rx_en = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("rst_mid_div_after", baud_div_o, 434);
    check("rst_mid_pending_after", cfg_pending, 0);
    check("rst_mid_no_pulses", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
